// File: rtl/tt_um_franc_mendez_pkg.sv
// Shared types and constants for the "1011" sequence detector tile.
// State codes are fixed because they appear on the debug pins.
package tt_um_franc_mendez_pkg;

    localparam int          ST_W      = 3;
    localparam logic [7:0]  COUNT_MAX = 8'hFF;

    typedef enum logic [ST_W-1:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        MATCH = 3'd4
    } state_e;

endpackage

// File: rtl/tt_um_franc_mendez_if.sv
// Bit-stream / match-status bundle between the tile top and the detector FSM.
// The master qualifies bits, the slave reports state, match level and entry.
interface tt_um_franc_mendez_if;
    import tt_um_franc_mendez_pkg::*;

    logic   bit_valid;
    logic   bit_data;
    state_e state;
    logic   match_lvl;
    logic   match_pulse;
    logic   match_enter;

    modport master (
        output bit_valid, bit_data,
        input  state, match_lvl, match_pulse, match_enter
    );

    modport slave (
        input  bit_valid, bit_data,
        output state, match_lvl, match_pulse, match_enter
    );

endinterface

// File: rtl/tt_um_franc_mendez_fsm.sv
// Overlapping Moore detector for the serial pattern "1011" plus match pulse.
//   state | meaning
//   S0    | nothing useful seen
//   S1    | last accepted bit was "1"
//   S10   | seen "10"
//   S101  | seen "101"
//   MATCH | seen "1011"; overlap keeps the trailing "1"
module seq_det_fsm
    import tt_um_franc_mendez_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    tt_um_franc_mendez_if.slave  fsm_if
);

    state_e state_q, state_d;
    logic   pulse_q, pulse_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        case (state_q)
            S0:    if (fsm_if.bit_valid) state_d = fsm_if.bit_data ? S1    : S0;
            S1:    if (fsm_if.bit_valid) state_d = fsm_if.bit_data ? S1    : S10;
            S10:   if (fsm_if.bit_valid) state_d = fsm_if.bit_data ? S101  : S0;
            S101:  if (fsm_if.bit_valid) state_d = fsm_if.bit_data ? MATCH : S10;
            MATCH: if (fsm_if.bit_valid) state_d = fsm_if.bit_data ? S1    : S10;
            // Unused codes recover on the next edge regardless of bit_valid
            default: state_d = S0;
        endcase
        // MATCH never loops to itself, so reaching it on a valid bit is always an entry
        pulse_d = fsm_if.bit_valid && (state_d == MATCH);
    end

    assign fsm_if.state       = state_q;
    assign fsm_if.match_lvl   = (state_q == MATCH);
    assign fsm_if.match_pulse = pulse_q;
    assign fsm_if.match_enter = pulse_d;

endmodule

// File: rtl/tt_um_franc_mendez.sv
// Tiny Tapeout tile: "1011" detector with saturating match counter on uio_out.
// Build with FSM_DEBUG_EN defined to expose the state code on uo_out[4:2].
module tt_um_franc_mendez
    import tt_um_franc_mendez_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    tt_um_franc_mendez_if det_if ();

    logic               clr;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [ST_W-1:0]    dbg_state;

    // ena gates acceptance, so a disabled tile never moves the FSM or pulses
    assign det_if.bit_valid = ena & ui_in[1];
    assign det_if.bit_data  = ui_in[0];
    assign clr              = ena & ui_in[2];

    seq_det_fsm u_fsm (
        .clk_i  (clk),
        .rst_i  (rst),
        .fsm_if (det_if)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (det_if.match_enter && (cnt_q != COUNT_W'(COUNT_MAX))) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef FSM_DEBUG_EN
    assign dbg_state = det_if.state;
`else
    assign dbg_state = '0;
`endif

    assign uo_out  = {3'b000, dbg_state, det_if.match_pulse, det_if.match_lvl};
    assign uio_out = cnt_q;
    assign uio_oe  = 8'hFF;

    logic unused_pins;
    assign unused_pins = &{1'b0, ui_in[7:3], uio_in};

endmodule

// File: tb/tb_tt_um_franc_mendez.sv
// Scoreboard bench for the "1011" detector tile; model tracks the last four
// accepted bits and derives state as the longest suffix that prefixes "1011".
module tb_tt_um_franc_mendez;
    import tt_um_franc_mendez_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_franc_mendez_if tb_if ();

    always #5 clk = ~clk;

    tt_um_franc_mendez dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    assign tb_if.state       = state_e'(uo_out[4:2]);
    assign tb_if.match_lvl   = uo_out[0];
    assign tb_if.match_pulse = uo_out[1];
    assign tb_if.match_enter = 1'b0;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [3:0] m_hist;
    int         m_cnt;
    bit         m_pulse;

    function automatic int model_state(input logic [3:0] h);
        if (h == 4'b1011)      return 4;
        if (h[2:0] == 3'b101)  return 3;
        if (h[1:0] == 2'b10)   return 2;
        if (h[0] == 1'b1)      return 1;
        return 0;
    endfunction

    task automatic step(input bit r, input bit e, input bit vld, input bit b,
                        input bit clr, input string tag);
        logic [4:0] junk;
        logic [7:0] jio;
        exp_t       x;
        int         st;
        @(negedge clk);
        junk = 5'($urandom);
        jio  = 8'($urandom);
        tb_if.bit_valid = vld;
        tb_if.bit_data  = b;
        rst    = r;
        ena    = e;
        ui_in  = {junk, clr, tb_if.bit_valid, tb_if.bit_data};
        uio_in = jio;
        if (r) begin
            m_hist  = 4'b0000;
            m_cnt   = 0;
            m_pulse = 1'b0;
        end else if (e) begin
            m_pulse = 1'b0;
            if (vld) begin
                m_hist  = {m_hist[2:0], b};
                m_pulse = (model_state(m_hist) == 4);
            end
            if (clr)                         m_cnt = 0;
            else if (m_pulse && m_cnt < 255) m_cnt = m_cnt + 1;
        end else begin
            m_pulse = 1'b0;
        end
        st = model_state(m_hist);
`ifdef FSM_DEBUG_EN
        x.uo = {3'b000, 3'(st), m_pulse, (st == 4)};
`else
        x.uo = {3'b000, 3'b000, m_pulse, (st == 4)};
`endif
        x.uio = 8'(m_cnt);
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic bits(input logic [15:0] pat, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) step(0, 1, 1, pat[i], 0, tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (uo_out !== e.uo) begin
                    errors++;
                    $display("FAIL %s uo_out: got %h expected %h", e.tag, uo_out, e.uo);
                end
                checks++;
                if (uio_out !== e.uio) begin
                    errors++;
                    $display("FAIL %s uio_out: got %h expected %h", e.tag, uio_out, e.uio);
                end
                checks++;
                if (uio_oe !== 8'hFF) begin
                    errors++;
                    $display("FAIL %s uio_oe: got %h expected ff", e.tag, uio_oe);
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        rst    = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tb_if.bit_valid = 1'b0;
        tb_if.bit_data  = 1'b0;
        m_hist  = 4'b0000;
        m_cnt   = 0;
        m_pulse = 1'b0;

        repeat (2) step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "reset");

        bits(16'b1011, 4, "basic");
        step(0, 1, 0, 0, 0, "basic_hold");

        step(1, 1, 0, 0, 0, "rst2");
        bits(16'b1011011, 7, "overlap");
        step(0, 1, 0, 1, 0, "overlap_hold");

        step(1, 1, 0, 0, 0, "rst3");
        bits(16'b101, 3, "gap");
        repeat (3) step(0, 1, 0, 1'($urandom), 0, "gap_idle");
        bits(16'b1, 1, "gap_end");
        step(0, 1, 0, 0, 0, "gap_hold");

        step(1, 1, 0, 0, 0, "rst4");
        bits(16'b101, 3, "ena_gap");
        repeat (3) step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), "ena_idle");
        bits(16'b1, 1, "ena_end");
        step(0, 0, 1, 0, 1, "ena_off_after");

        step(1, 1, 0, 0, 0, "rst5");
        bits(16'b1011, 4, "sat");
        for (int i = 0; i < 259; i++) bits(16'b011, 3, "sat");
        step(0, 1, 0, 0, 0, "sat_hold");
        bits(16'b01, 2, "clr_pre");
        step(0, 1, 1, 1, 1, "clr_match");
        step(0, 1, 0, 0, 0, "clr_after");

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 29) == 0),
                 "random");
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
